id_inst_buffer: RTL and testbench
=================================

# id_inst_buffer

Parametrised instruction buffer between IF and ID that decouples fetch from decode stalls. It holds up to DEPTH fetched `{PC_plus_4, inst}` entries and presents them in order to ID with a valid/allow_in handshake. A whole-buffer flush discards everything when ID resolves a redirect (taken beq/bne, jal, jr). It replaces the single IF_to_ID register, so a stall in ID no longer stalls IF immediately.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- DATA_WD, 64, entry width; default carries `{PC_plus_4[31:0], inst[31:0]}`.
- CNT_WD, $clog2(DEPTH+1), width of the occupancy count.

Ports (reset: synchronous, active-high; clock: clk):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  discard all entries and any push in the same cycle.
- in_valid  in  1  IF offers an entry (IF_to_ID_valid).
- in_allow  out  1  buffer can accept an entry (replaces ID_allow_in toward IF).
- in_data  in  DATA_WD  entry from IF.
- out_valid  out  1  head entry is valid for ID.
- out_ready  in  1  ID consumes the head this cycle (ID_allow_in).
- out_data  out  DATA_WD  head entry.
- count  out  CNT_WD  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation

- Storage is a circular array of DEPTH entries with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is held in a register and is not derived from the pointers.
- push = in_valid & in_allow & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_allow = ~full. It is registered-state only and has no combinational path from out_ready. A push is therefore refused when the buffer is full, even if a pop happens in the same cycle.
- out_valid = ~empty. out_data = mem[rd_ptr]. Both come from registered state; there is no combinational path from in_data or in_valid.
- push only: mem[wr_ptr] <= in_data, wr_ptr++, count++.
- pop only: rd_ptr++, count--.
- push and pop together: both pointers advance and count is unchanged. This includes count == 1, where the popped entry is the old head and the new entry is written behind it.
- flush: on the next edge wr_ptr, rd_ptr and count all go to 0. Any concurrent push or pop is ignored. mem contents are don't-care.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- mem is not reset. Its contents are unobservable while the corresponding entry is invalid.

## Timing

- Reset values: count = 0, empty = 1, full = 0, out_valid = 0, in_allow = 1, out_data = don't-care, wr_ptr = rd_ptr = 0.
- Latency: an entry pushed at edge N is visible on out_valid/out_data after edge N. ID sees it in cycle N+1, with no same-cycle passthrough.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Full boundary: with count == DEPTH, in_allow = 0 for the whole cycle. The earliest a new push is accepted is the cycle after the first pop.
- Empty boundary: with count == 0, out_valid = 0, and out_ready has no effect.
- Wrap-around: pointers roll from DEPTH-1 to 0 without a bubble.
- Flush and reset take effect at the same edge. Reset wins over flush; both produce the empty state.
- Reset asserted mid-operation returns to the empty state at the next edge, regardless of in_valid, out_ready or flush.
- count, full and empty update at the same edge as the pointers, never a cycle later.

## Test plan

- Reset then idle: assert reset for 2 cycles with in_valid=1. Required: count=0, out_valid=0, in_allow=1 throughout, and no entry is stored.
- Fill/drain (DEPTH=4): push 0x11..0x44 in 4 consecutive cycles with out_ready=0. Required: count steps 1,2,3,4, and full=1 / in_allow=0 after the 4th edge. A 5th in_valid with data 0x55 is refused. Then out_ready=1 for 4 cycles; required out_data is 0x11,0x22,0x33,0x44 in that order, then empty=1.
- Streaming with wrap: hold in_valid=1 and out_ready=1 for 10 cycles with data 1..10. Required: after the first push, count stays at 1, and out_data follows 1..10 one cycle behind the input with no bubbles as the pointers wrap twice.
- Full plus pop: at count=4, drive in_valid=1 and out_ready=1. Required: the pop happens, the push is refused, and count=3. On the next cycle the push is accepted and count returns to 4.
- Flush races: at count=3, assert flush together with in_valid=1 and out_ready=1. Required: next cycle count=0, out_valid=0, and neither the pushed nor the popped entry appears later. A push on the cycle after flush becomes the head with count=1.
- Parameter sweep: repeat fill/drain and streaming with DEPTH=2 and DEPTH=8. Required: full asserts at exactly count=DEPTH, and CNT_WD is wide enough to show 8.

Source files
------------

// File: rtl/id_inst_buffer.sv
// id_inst_buffer: in-order instruction buffer between IF and ID.
// Holds up to DEPTH {PC_plus_4, inst} entries in a circular array, presents the
// head to ID with a valid/ready handshake, and drops everything on a redirect flush.
// Handshake outputs depend only on registered state, so ID stalls never reach IF
// combinationally.
module id_inst_buffer #(
  parameter int DEPTH   = 4,
  parameter int DATA_WD = 64,
  parameter int CNT_WD  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_allow,
  input  logic [DATA_WD-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_WD-1:0] out_data,
  output logic [CNT_WD-1:0]  count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_WD = $clog2(DEPTH);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_WD-1:0]  wr_ptr_reg;
  logic [PTR_WD-1:0]  rd_ptr_reg;
  logic [CNT_WD-1:0]  count_reg;
  logic               push;
  logic               pop;

  // Status and handshake come straight from the occupancy register.
  always_comb begin
    full      = (count_reg == CNT_WD'(DEPTH));
    empty     = (count_reg == '0);
    in_allow  = ~full;
    out_valid = ~empty;
    out_data  = mem[rd_ptr_reg];
    count     = count_reg;
    push      = in_valid & in_allow & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Entry storage: written at the tail on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // Pointer and occupancy update; reset and flush both return to empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_WD'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_WD'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_WD'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_WD'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// tb_id_inst_buffer: directed scoreboard bench for id_inst_buffer at DEPTH 2, 4, 8.
// Stimulus pushes hand-chosen expected entries into per-instance queues; a
// negedge monitor pops and compares whenever an instance hands an entry to ID.
module tb_id_inst_buffer;

  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic        flush_a     [NI];
  logic        in_valid_a  [NI];
  logic        in_allow_a  [NI];
  logic [63:0] in_data_a   [NI];
  logic        out_valid_a [NI];
  logic        out_ready_a [NI];
  logic [63:0] out_data_a  [NI];
  logic [3:0]  count_a     [NI];
  logic        full_a      [NI];
  logic        empty_a     [NI];

  logic [63:0] exp_q [NI][$];
  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int D = 2 << gi;
      logic [$clog2(D+1)-1:0] cnt_w;
      id_inst_buffer #(.DEPTH(D), .DATA_WD(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_a[gi]),
        .in_valid  (in_valid_a[gi]),
        .in_allow  (in_allow_a[gi]),
        .in_data   (in_data_a[gi]),
        .out_valid (out_valid_a[gi]),
        .out_ready (out_ready_a[gi]),
        .out_data  (out_data_a[gi]),
        .count     (cnt_w),
        .full      (full_a[gi]),
        .empty     (empty_a[gi])
      );
      assign count_a[gi] = 4'(cnt_w);
    end
  endgenerate

  // Monitor: every handshake the DUT completes must match the oldest expected entry.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!reset && out_valid_a[k] && out_ready_a[k] && !flush_a[k]) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected inst%0d actual %h required no entry", k, out_data_a[k]);
        end else begin
          logic [63:0] e;
          e = exp_q[k].pop_front();
          if (out_data_a[k] !== e) begin
            errors++;
            $display("FAIL out_data inst%0d actual %h required %h", k, out_data_a[k], e);
          end else begin
            $display("pop  inst%0d data %h", k, out_data_a[k]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int i, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s inst%0d actual %0d required %0d", name, i, act, req);
    end
  endtask

  // One cycle on instance i; acc is the hand-decided acceptance, ec the count after the edge.
  task automatic step(input int i, input bit v, input logic [63:0] d, input bit r,
                      input bit f, input bit acc, input int ec);
    int dep;
    dep = 2 << i;
    in_valid_a[i]  = v;
    in_data_a[i]   = d;
    out_ready_a[i] = r;
    flush_a[i]     = f;
    if (f) exp_q[i].delete();
    if (v && !f) check("in_allow", i, int'(in_allow_a[i]), int'(acc));
    if (acc) exp_q[i].push_back(d);
    @(posedge clk); #1;
    check("count", i, int'(count_a[i]), ec);
    check("full", i, int'(full_a[i]), (ec == dep) ? 1 : 0);
    check("empty", i, int'(empty_a[i]), (ec == 0) ? 1 : 0);
    check("out_valid", i, int'(out_valid_a[i]), (ec != 0) ? 1 : 0);
    $display("step inst%0d v=%0d d=%h r=%0d f=%0d count=%0d", i, v, d, r, f, count_a[i]);
    in_valid_a[i]  = 1'b0;
    out_ready_a[i] = 1'b0;
    flush_a[i]     = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int k = 0; k < NI; k++) in_valid_a[k] = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        check("rst_count", k, int'(count_a[k]), 0);
        check("rst_out_valid", k, int'(out_valid_a[k]), 0);
        check("rst_in_allow", k, int'(in_allow_a[k]), 1);
      end
      $display("reset cycle %0d", c);
    end
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid_a[k] = 1'b0;
      exp_q[k].delete();
    end
  endtask

  task automatic drained(input int i);
    check("drained", i, exp_q[i].size(), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      flush_a[k] = 1'b0; in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0; in_data_a[k] = '0;
    end
    @(posedge clk); #1;
    do_reset(2);

    for (int i = 0; i < NI; i++) begin
      int dep;
      int n;
      dep = 2 << i;

      // Fill to full, refuse one more, then drain in order.
      for (int k = 0; k < dep; k++) step(i, 1, 64'((k + 1) * 'h11), 0, 0, 1, k + 1);
      step(i, 1, 64'h55, 0, 0, 0, dep);
      for (int k = 0; k < dep; k++) step(i, 0, 0, 1, 0, 0, dep - 1 - k);
      drained(i);

      // Streaming 1..10: count holds at 1 while pointers wrap.
      step(i, 1, 64'd1, 1, 0, 1, 1);
      for (int k = 2; k <= 10; k++) step(i, 1, 64'(k), 1, 0, 1, 1);
      step(i, 0, 0, 1, 0, 0, 0);
      drained(i);

      // Full plus pop: pop happens, push refused, accepted next cycle.
      for (int k = 0; k < dep; k++) step(i, 1, 64'('hA0 + k), 0, 0, 1, k + 1);
      step(i, 1, 64'hB0, 1, 0, 0, dep - 1);
      step(i, 1, 64'hB1, 0, 0, 1, dep);
      for (int k = 0; k < dep; k++) step(i, 0, 0, 1, 0, 0, dep - 1 - k);
      drained(i);

      // Flush racing with push and pop; next push becomes the head.
      n = (dep < 3) ? dep : 3;
      for (int k = 0; k < n; k++) step(i, 1, 64'('hC1 + k), 0, 0, 1, k + 1);
      step(i, 1, 64'hCF, 1, 1, 0, 0);
      step(i, 1, 64'hD1, 0, 0, 1, 1);
      step(i, 0, 0, 1, 0, 0, 0);
      drained(i);

      // Reset in the middle of operation.
      step(i, 1, 64'hE1, 0, 0, 1, 1);
      step(i, 1, 64'hE2, 0, 0, 1, 2);
      do_reset(1);
      step(i, 1, 64'hF1, 0, 0, 1, 1);
      step(i, 0, 0, 1, 0, 0, 0);
      drained(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
